// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - round-robin arbiter sharing one AXI read channel between icache and dcache
module axi_read_arbiter #(
  parameter int BURST_LEN = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic        inst_cached,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  output logic        inst_rlast,
  input  logic        data_req,
  input  logic        data_cached,
  input  logic [31:0] data_addr,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  output logic        data_rlast,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        burst_err
);

  localparam logic [7:0] LEN_M1 = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, AR_REQ, R_DATA} state_t;

  state_t      state_q, state_d;
  logic        grant_q;       // 0 = inst, 1 = data
  logic        last_grant_q;  // requester served most recently
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [1:0]  arburst_q;
  logic [3:0]  arid_q;
  logic [3:0]  beat_cnt_q;

  logic any_req;
  logic pick_data;
  logic sel_cached;
  logic ar_hs;
  logic beat_ok;
  logic cnt_at_last;

  // Response status is not used for control and is not forwarded.
  logic unused_rresp;
  assign unused_rresp = ^rresp;

  // On a tie, the requester that was not served last wins.
  assign any_req    = inst_req | data_req;
  assign pick_data  = (inst_req & data_req) ? ~last_grant_q : data_req;
  assign sel_cached = pick_data ? data_cached : inst_cached;

  assign ar_hs       = (state_q == AR_REQ) & arready;
  assign beat_ok     = (state_q == R_DATA) & rvalid;
  assign cnt_at_last = (beat_cnt_q == arlen_q[3:0]);

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: completion happens only on an accepted rlast beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)         state_d = AR_REQ;
      AR_REQ:  if (arready)         state_d = R_DATA;
      R_DATA:  if (rvalid && rlast) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Grant, registered AR fields, fairness pointer and beat counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      araddr_q     <= 32'd0;
      arlen_q      <= 8'd0;
      arburst_q    <= 2'b00;
      arid_q       <= 4'd0;
      beat_cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q   <= pick_data;
            araddr_q  <= pick_data ? data_addr : inst_addr;
            arlen_q   <= sel_cached ? LEN_M1 : 8'd0;
            arburst_q <= sel_cached ? 2'b01 : 2'b00;
            arid_q    <= {3'b000, pick_data};
          end
        end
        AR_REQ: begin
          if (arready) begin
            beat_cnt_q   <= 4'd0;
            last_grant_q <= grant_q;
          end
        end
        R_DATA: begin
          if (rvalid) beat_cnt_q <= beat_cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign arvalid = (state_q == AR_REQ);
  assign rready  = (state_q == R_DATA);
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arburst = arburst_q;
  assign arid    = arid_q;
  assign arsize  = 3'b010;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign inst_addr_ok = ar_hs & ~grant_q;
  assign data_addr_ok = ar_hs &  grant_q;

  assign inst_rdata  = rdata;
  assign data_rdata  = rdata;
  assign inst_rvalid = beat_ok & ~grant_q;
  assign data_rvalid = beat_ok &  grant_q;
  assign inst_rlast  = inst_rvalid & rlast;
  assign data_rlast  = data_rvalid & rlast;

  // Wrong id, early/late rlast are flagged on the offending beat only.
  assign burst_err = beat_ok & ((rid != arid_q) | (rlast ? ~cnt_at_last : cnt_at_last));

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - directed self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, inst_cached;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_rvalid, inst_rlast;
  logic        data_req, data_cached;
  logic [31:0] data_addr;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_rvalid, data_rlast;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, burst_err;

  int total = 0;
  int bad   = 0;
  int beats;

  always #5 aclk = ~aclk;

  axi_read_arbiter #(.BURST_LEN(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_cached(inst_cached), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata),
    .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast),
    .data_req(data_req), .data_cached(data_cached), .data_addr(data_addr),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
    .data_rvalid(data_rvalid), .data_rlast(data_rlast),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .burst_err(burst_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Wait (bounded) for AR, handshake, return one single beat and release the requester.
  task automatic serve_single(input string tag, input logic exp_id, input logic [31:0] exp_addr);
    for (int i = 0; i < 10 && !arvalid; i++) tick;
    chk({tag, "_arvalid"}, arvalid, 1);
    chk({tag, "_arid"}, arid, {31'd0, exp_id});
    chk({tag, "_araddr"}, araddr, exp_addr);
    chk({tag, "_arlen"}, arlen, 0);
    arready = 1'b1;
    #1;
    chk({tag, "_addr_ok"}, exp_id ? data_addr_ok : inst_addr_ok, 1);
    chk({tag, "_other_ok"}, exp_id ? inst_addr_ok : data_addr_ok, 0);
    tick;
    arready = 1'b0;
    if (exp_id) data_req = 1'b0; else inst_req = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rid = {3'b000, exp_id}; rdata = exp_addr ^ 32'h5A5A_0000;
    #1;
    chk({tag, "_rvalid"}, exp_id ? data_rvalid : inst_rvalid, 1);
    chk({tag, "_other_rvalid"}, exp_id ? inst_rvalid : data_rvalid, 0);
    chk({tag, "_err"}, burst_err, 0);
    tick;
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    inst_req = 0; inst_cached = 0; inst_addr = 0;
    data_req = 0; data_cached = 0; data_addr = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    tick; tick;

    // Reset state
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_burst_err", burst_err, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_arsize", arsize, 3'b010);
    chk("rst_arlock_cache_prot", {arlock, arcache, arprot}, 0);
    aresetn = 1'b1;
    tick;

    // Test 1: uncached inst read with arready delayed
    inst_req = 1; inst_cached = 0; inst_addr = 32'h1FC0_0000;
    #1;
    chk("t1_idle_arvalid", arvalid, 0);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("t1_arvalid_held", arvalid, 1);
      chk("t1_arlen", arlen, 0);
      chk("t1_arburst", arburst, 0);
      chk("t1_arid", arid, 0);
      chk("t1_araddr", araddr, 32'h1FC0_0000);
      chk("t1_no_addr_ok", inst_addr_ok, 0);
      tick;
    end
    arready = 1;
    #1;
    chk("t1_addr_ok", inst_addr_ok, 1);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    tick;
    arready = 0; inst_req = 0;
    chk("t1_rready", rready, 1);
    chk("t1_arvalid_drop", arvalid, 0);
    chk("t1_addr_ok_pulse", inst_addr_ok, 0);
    rvalid = 1; rlast = 1; rid = 0; rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_inst_rvalid", inst_rvalid, 1);
    chk("t1_inst_rlast", inst_rlast, 1);
    chk("t1_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
    chk("t1_data_rvalid", data_rvalid, 0);
    chk("t1_data_rlast", data_rlast, 0);
    chk("t1_err", burst_err, 0);
    tick;
    rvalid = 0; rlast = 0;
    chk("t1_done_rready", rready, 0);

    // Test 2: cached data refill, 16 beats with random gaps
    data_req = 1; data_cached = 1; data_addr = 32'h8000_1000;
    tick;
    chk("t2_arvalid", arvalid, 1);
    chk("t2_arlen", arlen, 8'h0F);
    chk("t2_arburst", arburst, 2'b01);
    chk("t2_arid", arid, 1);
    chk("t2_araddr", araddr, 32'h8000_1000);
    arready = 1;
    #1;
    chk("t2_addr_ok", data_addr_ok, 1);
    tick;
    arready = 0; data_req = 0; data_cached = 0;
    beats = 0;
    for (int c = 0; c < 200 && beats < 16; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        rvalid = 1; rid = 1; rdata = 32'hA000_0000 + beats; rlast = (beats == 15);
        #1;
        chk("t2_data_rvalid", data_rvalid, 1);
        chk("t2_data_rlast", data_rlast, (beats == 15));
        chk("t2_data_rdata", data_rdata, 32'hA000_0000 + beats);
        chk("t2_inst_rvalid", inst_rvalid, 0);
        chk("t2_err", burst_err, 0);
        beats++;
      end else begin
        rvalid = 0; rlast = 0;
        #1;
        chk("t2_gap_rvalid", data_rvalid, 0);
        chk("t2_gap_err", burst_err, 0);
      end
      tick;
    end
    rvalid = 0; rlast = 0;
    chk("t2_beats", beats, 16);
    chk("t2_done_rready", rready, 0);

    // Test 3: simultaneous requests after reset alternate data/inst/data/inst
    aresetn = 0;
    tick;
    aresetn = 1;
    inst_req = 1; inst_addr = 32'h0000_1100;
    data_req = 1; data_addr = 32'h0000_2200;
    serve_single("t3_first_data", 1'b1, 32'h0000_2200);
    serve_single("t3_then_inst", 1'b0, 32'h0000_1100);
    inst_req = 1; data_req = 1;
    serve_single("t3_again_data", 1'b1, 32'h0000_2200);
    serve_single("t3_again_inst", 1'b0, 32'h0000_1100);

    // Test 4: request raised during another burst waits for IDLE
    inst_req = 1; inst_addr = 32'h0000_0100;
    tick;
    arready = 1;
    tick;
    arready = 0; inst_req = 0;
    data_req = 1; data_addr = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_arvalid_in_rdata", arvalid, 0);
      tick;
    end
    rvalid = 1; rlast = 1; rid = 0; rdata = 32'h1234_5678;
    #1;
    chk("t4_inst_rlast", inst_rlast, 1);
    tick;
    rvalid = 0; rlast = 0;
    chk("t4_m1_arvalid", arvalid, 0);
    tick;
    chk("t4_m2_arvalid", arvalid, 1);
    chk("t4_m2_arid", arid, 1);
    arready = 1;
    tick;
    arready = 0; data_req = 0;
    rvalid = 1; rlast = 1; rid = 1;
    #1;
    chk("t4_data_rvalid", data_rvalid, 1);
    tick;
    rvalid = 0; rlast = 0;

    // Test 5a: early rlast on beat 8 of a 16-beat inst burst
    inst_req = 1; inst_cached = 1; inst_addr = 32'h0000_3000;
    tick;
    chk("t5_arlen", arlen, 8'h0F);
    arready = 1;
    tick;
    arready = 0; inst_req = 0; inst_cached = 0;
    for (int b = 0; b < 7; b++) begin
      rvalid = 1; rlast = 0; rid = 0;
      #1;
      chk("t5_pre_err", burst_err, 0);
      tick;
    end
    rlast = 1;
    #1;
    chk("t5_early_rlast_err", burst_err, 1);
    chk("t5_inst_rlast", inst_rlast, 1);
    tick;
    rvalid = 0; rlast = 0;
    #1;
    chk("t5_err_pulse", burst_err, 0);
    chk("t5_idle_rready", rready, 0);

    // Test 5b: wrong rid on a data burst
    data_req = 1; data_addr = 32'h0000_4000;
    tick;
    arready = 1;
    tick;
    arready = 0; data_req = 0;
    rvalid = 1; rlast = 1; rid = 0;
    #1;
    chk("t5_rid_err", burst_err, 1);
    chk("t5_rid_data_rvalid", data_rvalid, 1);
    tick;
    rvalid = 0; rlast = 0;
    chk("t5_rid_idle_rready", rready, 0);

    // Test 6: reset in the middle of R_DATA
    data_req = 1; data_cached = 1; data_addr = 32'h8000_2000;
    tick;
    arready = 1;
    tick;
    arready = 0; data_req = 0; data_cached = 0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1; rlast = 0; rid = 1;
      #1;
      chk("t6_beat_rvalid", data_rvalid, 1);
      tick;
    end
    rvalid = 0;
    aresetn = 0;
    tick;
    aresetn = 1;
    chk("t6_rst_arvalid", arvalid, 0);
    chk("t6_rst_rready", rready, 0);
    inst_req = 1; inst_addr = 32'h0000_5100;
    data_req = 1; data_addr = 32'h0000_5200;
    serve_single("t6_after_rst_data", 1'b1, 32'h0000_5200);
    serve_single("t6_after_rst_inst", 1'b0, 32'h0000_5100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Sequential arbiter that shares the CPU's single AXI read channel (AR + R) between the instruction-cache and data-cache refill engines. It grants one requester at a time, with round-robin fairness, and drives a registered AR request: a 16-beat INCR burst for cached refills, or a single beat for uncached accesses. It holds the grant until the final R beat is returned, routing each beat only to the granted requester. It sits between the two cache controllers and the AXI read ports of the CPU top.

## Interface
- BURST_LEN, 16, beats per cached refill; arlen = BURST_LEN-1.
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  reset, synchronous, active-low.
- inst_req  in  1  icache read request; held with inst_addr/inst_cached until inst_addr_ok.
- inst_cached  in  1  1 = burst refill, 0 = single beat.
- inst_addr  in  32  start address.
- inst_addr_ok  out  1  one-cycle pulse on the AR handshake for inst.
- inst_rdata  out  32  R data (passthrough).
- inst_rvalid  out  1  beat valid for inst.
- inst_rlast  out  1  last beat for inst.
- data_req, data_cached, data_addr, data_addr_ok, data_rdata, data_rvalid, data_rlast: same as the inst_* ports, for the dcache.
- arid  out  4  0 = inst, 1 = data.
- araddr  out  32  registered request address.
- arlen  out  8  BURST_LEN-1 if cached, else 0.
- arsize  out  3  constant 3'b010.
- arburst  out  2  2'b01 if cached, else 2'b00.
- arlock/arcache/arprot  out  2/4/3  constant 0.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  read id.
- rdata  in  32  read data.
- rresp  in  2  ignored for control; not forwarded.
- rlast  in  1  last beat.
- rvalid  in  1  beat valid.
- rready  out  1  1 only in R_DATA.
- burst_err  out  1  one-cycle pulse on a protocol mismatch.

## Operation
- States: IDLE, AR_REQ, R_DATA.
- IDLE: if exactly one req is high, grant it. If both are high, grant the requester not equal to `last_grant`. Register the grant, the address, cached/arlen/arburst and arid, then go to AR_REQ.
- `last_grant` resets to inst, so data wins the first tie.
- AR_REQ: arvalid=1 and AR fields are stable until arready.
  - On arvalid&arready: pulse the granted *_addr_ok, clear the beat counter, update last_grant, go to R_DATA.
- R_DATA: rready=1.
  - Granted *_rvalid = rvalid; *_rlast = rvalid&rlast; both *_rdata = rdata. The non-granted rvalid/rlast are 0.
  - The 4-bit beat counter increments on each rvalid.
  - On rvalid&rlast, go to IDLE.
- burst_err pulses on an accepted beat if either of these holds:
  - rid != the registered arid;
  - rlast arrives with beat count != arlen[3:0], or the count reaches arlen without rlast.
  
  Completion still occurs only on rlast.
- A request deasserted before addr_ok is a requester protocol violation. The arbiter keeps the registered request and completes it.
- Reset: state=IDLE, last_grant=inst, counter=0. Registered AR fields reset to 0.
  - Outputs at reset: arvalid, rready, *_addr_ok, *_rvalid, *_rlast and burst_err are all 0.
  - Reset mid-burst abandons the burst without draining it; the slave is reset with the same aresetn.

## Timing
- Request sampled in IDLE at cycle N -> arvalid=1 at N+1.
- addr_ok is asserted in the cycle of the AR handshake, and state moves to R_DATA at the next cycle.
- R beats are combinational passthrough, with zero added latency.
- After the rlast beat at cycle M, state is IDLE at M+1. The next grant is sampled at M+1 and arvalid is asserted at M+2.
- Minimum turnaround between bursts is 2 idle AR cycles.
- arvalid never drops before arready.
- AR fields do not change while arvalid=1 && !arready.
- rready=0 in IDLE and AR_REQ; no beats are accepted outside R_DATA.

## Test plan
- Single uncached inst read, addr 0x1FC00000, arready delayed 3 cycles:
  - arvalid held 3 cycles with arlen=0, arburst=0, arid=0;
  - inst_addr_ok pulses on the handshake;
  - 1 beat 0xDEADBEEF is routed to inst with inst_rlast=1;
  - data_rvalid stays 0.
- Cached data refill at 0x80001000, 16 beats with random rvalid gaps:
  - arlen=0x0F, arburst=1, arid=1;
  - 16 data_rvalid pulses, data_rlast only on beat 16;
  - burst_err never asserts.
- Simultaneous inst_req and data_req after reset, both held:
  - data is granted first, then inst;
  - repeated simultaneous requests alternate data/inst/data.
- New request raised during R_DATA of another burst:
  - no arvalid until state returns to IDLE;
  - arvalid for the new request asserts exactly 2 cycles after the rlast beat.
- Slave returns rlast on beat 8 of a 16-beat burst, then separately rid=0 on a data burst:
  - burst_err pulses on the offending beat;
  - FSM returns to IDLE after rlast.
- aresetn low for 1 cycle in the middle of R_DATA:
  - next cycle state is IDLE with arvalid=0 and rready=0;
  - last_grant resets to inst;
  - a subsequent request is granted normally.
